// File: rtl/logic_capture_buffer.sv
// -----------------------------------------------------------------------------
// logic_capture_buffer
// Multi-channel logic-analyser capture buffer. After arm, samples (taken only
// on ena=1 cycles) are written into a circular buffer. PRETRIG samples are kept
// ahead of the trigger; the trigger sample plus the following samples fill the
// rest of the DEPTH-entry window. The window is then read out oldest first,
// one sample per rd_req pulse.
//
// Optional feature macro: CAPTURE_EDGE_TRIG_EN
//   defined   -> trigger on a rising edge of the match condition
//   undefined -> trigger on the match level
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   ena        sample enable
//   sample_in  channel inputs            [CHANNELS]
//   trig_mask  1 = channel in trigger    [CHANNELS]
//   trig_value required level per channel[CHANNELS]
//   arm        start-capture pulse (honoured only in IDLE)
//   rd_req     readout request, one sample per pulse (honoured only in DONE)
//   rd_data    read sample, held while rd_valid=0 [CHANNELS]
//   rd_valid   one-cycle pulse marking rd_data
//   done       capture complete, buffer readable
//   state      FSM code: IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4
// -----------------------------------------------------------------------------
module logic_capture_buffer #(
   parameter int CHANNELS = 7,
   parameter int DEPTH    = 64,
   parameter int PRETRIG  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [CHANNELS-1:0] sample_in,
   input  logic [CHANNELS-1:0] trig_mask,
   input  logic [CHANNELS-1:0] trig_value,
   input  logic                arm,
   input  logic                rd_req,
   output logic [CHANNELS-1:0] rd_data,
   output logic                rd_valid,
   output logic                done,
   output logic [2:0]          state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] PRE_CNT  = CW'(PRETRIG);
   localparam logic [CW-1:0] POST_CNT = CW'(DEPTH - PRETRIG);
   localparam logic [AW-1:0] PRE_OFS  = AW'(PRETRIG);
   localparam logic [AW-1:0] RD_LAST  = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CHANNELS-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [AW-1:0]       r_trig_addr;
   logic [AW-1:0]       r_rd_cnt;
   logic [CW-1:0]       r_cnt;
   logic                r_done;
   logic                r_rd_valid;
   logic [CHANNELS-1:0] r_rd_data;

   logic w_match;
   logic w_trig;
   logic w_write;
   logic w_cnt_hit_pre;
   logic w_cnt_hit_post;
   logic w_read_last;

   assign w_match        = (((sample_in ^ trig_value) & trig_mask) == {CHANNELS{1'b0}});
   assign w_write        = ena && ((r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST));
   assign w_cnt_hit_pre  = ((r_cnt + CW'(1)) == PRE_CNT);
   assign w_cnt_hit_post = ((r_cnt + CW'(1)) == POST_CNT);
   assign w_read_last    = (r_state == S_DONE) && rd_req && (r_rd_cnt == RD_LAST);

`ifdef CAPTURE_EDGE_TRIG_EN
   logic r_prev_match;

   // Match history; held at 1 outside ARMED so a match already present on entry needs a mismatch first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_match <= 1'b1;
      end else if (r_state != S_ARMED) begin
         r_prev_match <= 1'b1;
      end else if (ena) begin
         r_prev_match <= w_match;
      end else begin
         r_prev_match <= r_prev_match;
      end
   end

   assign w_trig = (r_state == S_ARMED) && ena && w_match && !r_prev_match;
`else
   assign w_trig = (r_state == S_ARMED) && ena && w_match;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (arm) begin
               w_state_next = (PRE_CNT == {CW{1'b0}}) ? S_ARMED : S_PRE;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_PRE: begin
            if (ena && w_cnt_hit_pre) begin
               w_state_next = S_ARMED;
            end else begin
               w_state_next = S_PRE;
            end
         end
         S_ARMED: begin
            // A one-sample post window is filled by the trigger itself
            if (w_trig) begin
               w_state_next = (POST_CNT == CW'(1)) ? S_DONE : S_POST;
            end else begin
               w_state_next = S_ARMED;
            end
         end
         S_POST: begin
            if (ena && w_cnt_hit_post) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_POST;
            end
         end
         S_DONE: begin
            if (w_read_last) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_DONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Sample storage; contents survive reset
   always_ff @(posedge clk) begin
      if (rst_n && w_write) begin
         r_mem[r_wptr] <= sample_in;
      end
   end

   // Pointers, counters, trigger address and read port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr      <= {AW{1'b0}};
         r_rptr      <= {AW{1'b0}};
         r_trig_addr <= {AW{1'b0}};
         r_rd_cnt    <= {AW{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= {CHANNELS{1'b0}};
      end else begin
         r_rd_valid <= 1'b0;
         r_done     <= (w_state_next == S_DONE);
         if (w_write) begin
            r_wptr <= r_wptr + AW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_cnt <= {CW{1'b0}};
               end
            end
            S_PRE: begin
               if (ena) begin
                  // Cleared on the way to ARMED so it can count the post window
                  r_cnt <= w_cnt_hit_pre ? {CW{1'b0}} : (r_cnt + CW'(1));
               end
            end
            S_ARMED: begin
               if (w_trig) begin
                  r_trig_addr <= r_wptr;
                  r_cnt       <= CW'(1);
                  r_rptr      <= r_wptr - PRE_OFS;
                  r_rd_cnt    <= {AW{1'b0}};
               end
            end
            S_POST: begin
               if (ena) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (w_cnt_hit_post) begin
                     r_rptr   <= r_trig_addr - PRE_OFS;
                     r_rd_cnt <= {AW{1'b0}};
                  end
               end
            end
            S_DONE: begin
               if (rd_req) begin
                  r_rd_data  <= r_mem[r_rptr];
                  r_rd_valid <= 1'b1;
                  r_rptr     <= r_rptr + AW'(1);
                  r_rd_cnt   <= r_rd_cnt + AW'(1);
               end
            end
            default: begin
               r_cnt <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign state    = r_state;
   assign done     = r_done;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;

endmodule
